play_source_arbiter: RTL and testbench
======================================

Name: play_source_arbiter

Overview:
- Shares the single tone-generator interface (`key_on`/`key`) between the live keyboard and NUM_SONGS autoplay song players.
- Runs a mode FSM: free play or autoplay of a selected song, with live keys pre-empting autoplay.
- Inserts a silent gap on every mode or song switch.
- Sits between the keyboard decoder / song players and the tone generator. It drives the players' run enables and restart strobes.

Parameters:
- NUM_SONGS, 3: number of song-player inputs (2..4).
- KEY_W, 4: note-index width, shared with the tone generator.
- SEL_W, 2: width of `song_sel`; must satisfy 2**SEL_W >= NUM_SONGS.
- GAP_CYCLES, 5000000: length of the mute gap in clk cycles (0.1 s at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- kb_key_on  in  1  live keyboard note active.
- kb_key  in  KEY_W  live keyboard note index.
- song_key_on  in  NUM_SONGS  per-player note active; bit s belongs to player s.
- song_key  in  NUM_SONGS*KEY_W  per-player note; player s is at [s*KEY_W +: KEY_W].
- mode_btn  in  1  single-cycle debounced pulse; toggles FREE/AUTO.
- next_btn  in  1  single-cycle debounced pulse; advances to the next song (AUTO only).
- song_en  out  NUM_SONGS  one-hot run enable to the players.
- song_rst_n  out  NUM_SONGS  active-low one-cycle restart strobe per player.
- key_on  out  1  note active to the tone generator.
- key  out  KEY_W  note index to the tone generator.
- mode  out  1  0 = free play, 1 = autoplay (reflects the committed mode).
- song_sel  out  SEL_W  currently selected song.
- muting  out  1  high while in the gap.

Behaviour:
- All outputs are registered. Output latency from any input to key/key_on is exactly 1 cycle.
- Reset values (while rst==0):
  - FSM = FREE; song_sel = 0; mode = 0.
  - key_on = 0; key = 0; muting = 0.
  - song_en = 0; song_rst_n = all 0 (players held in reset).
  - Gap counter = 0; target = FREE.
- First cycle after reset release: song_rst_n = all 1.
- States: FREE, MUTE, AUTO. A `target` register (FREE/AUTO) records the destination of MUTE.
- FREE:
  - key_on <= kb_key_on; key <= kb_key; song_en = 0.
  - mode_btn -> MUTE with target = AUTO; song_sel is unchanged.
  - next_btn is ignored.
- AUTO:
  - song_en = one-hot(song_sel).
  - If kb_key_on == 1: key_on <= 1, key <= kb_key (live pre-emption). The song player keeps running.
  - Otherwise: key_on <= song_key_on[song_sel], key <= song_key[song_sel].
  - Unselected player inputs are never routed.
  - mode_btn -> MUTE with target = FREE.
  - next_btn -> MUTE with target = AUTO, and song_sel <= song_sel+1, wrapping NUM_SONGS-1 -> 0.
  - mode_btn and next_btn in the same cycle: mode_btn wins and song_sel is unchanged.
- MUTE:
  - key_on = 0; key holds its last value; song_en = 0; muting = 1.
  - Counter runs 0..GAP_CYCLES-1, so MUTE lasts exactly GAP_CYCLES cycles.
  - On the last MUTE cycle (counter == GAP_CYCLES-1):
    - If target == AUTO, song_rst_n[song_sel] = 0 for that one cycle.
    - Next state = target; counter clears; muting drops.
  - `mode` updates to the target on the MUTE->target transition, not on entry.
  - mode_btn and next_btn are ignored during MUTE (no queuing).
- Every entry to AUTO restarts the selected song from note 0. song_en[sel] asserts on the first AUTO cycle, the cycle after the restart strobe.
- Reset mid-MUTE or mid-AUTO: reset values apply on that edge. The pending target and counter are discarded.
- At most one bit of song_en is high, and song_rst_n has at most one low bit outside reset.

Decomposition:
- Shared package piano_pkg holds:
  - KEY_W and NUM_SONGS defaults;
  - the state encoding (FREE, MUTE, AUTO);
  - the default GAP_CYCLES constant.
- Sub-module gap_timer:
  - ports: clk, rst, start, done;
  - a GAP_CYCLES down/up counter whose `done` is high on the final count.
  - The FSM and routing mux stay in play_source_arbiter.

Test Plan (GAP_CYCLES = 4, NUM_SONGS = 3):
- Reset then FREE pass-through: hold rst=0 for 3 cycles, release, drive kb_key_on=1, kb_key=5 -> key_on=1, key=5 one cycle later; song_en=0; song_rst_n=3'b111 one cycle after release.
- Enter AUTO: pulse mode_btn in FREE -> muting=1 and key_on=0 for exactly 4 cycles; song_rst_n=3'b110 on the 4th; then mode=1, song_en=3'b001, and key follows song_key[3:0] with 1-cycle latency.
- Pre-emption: in AUTO with song 0 outputting key 2, set kb_key_on=1, kb_key=9 -> key=9; release -> key=2 next cycle; song_en stays 3'b001 throughout.
- Song wrap: from song_sel=2 pulse next_btn -> 4-cycle gap, song_rst_n=3'b110, song_sel=0, song_en=3'b001.
- Simultaneous and ignored buttons: in AUTO, song_sel=1, pulse mode_btn and next_btn together -> target FREE, song_sel remains 1. Pulse next_btn during the gap -> no effect; after the gap mode=0 and song_en=0.
- Reset mid-gap: assert rst=0 on gap cycle 2 -> FSM=FREE, muting=0, song_sel=0, song_en=0, song_rst_n=0 on the next edge.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano play path: default widths, the source
// arbiter state encoding and the default length of the silent switch gap.
package piano_pkg;

  localparam int KEY_W_DEF      = 4;
  localparam int NUM_SONGS_DEF  = 3;
  localparam int GAP_CYCLES_DEF = 5000000;

  // Arbiter modes; ST_FREE and ST_AUTO double as the gap destination.
  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_MUTE = 2'd1,
    ST_AUTO = 2'd2
  } state_t;

endpackage

// File: rtl/gap_timer.sv
// One-shot cycle counter. A start pulse arms it; it counts 0..LEN-1 on the
// following cycles and raises done during the final count, then goes idle.
module gap_timer #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  logic             running;
  logic [CNT_W-1:0] count;

  assign done = running && (count == CNT_W'(LEN - 1));

  // Arm on start, then step the count until the final value has been seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
    end else if (running) begin
      if (count == CNT_W'(LEN - 1)) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/play_source_arbiter.sv
// Shares the tone-generator key interface between the live keyboard and the
// autoplay song players, inserting a silent gap on every mode or song switch.
// Every output is a register whose value matches the state held in that
// cycle, so transitions also load the outputs of the state being entered.
module play_source_arbiter
  import piano_pkg::*;
#(
  parameter int NUM_SONGS  = NUM_SONGS_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int SEL_W      = 2,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       kb_key_on,
  input  logic [KEY_W-1:0]           kb_key,
  input  logic [NUM_SONGS-1:0]       song_key_on,
  input  logic [NUM_SONGS*KEY_W-1:0] song_key,
  input  logic                       mode_btn,
  input  logic                       next_btn,
  output logic [NUM_SONGS-1:0]       song_en,
  output logic [NUM_SONGS-1:0]       song_rst_n,
  output logic                       key_on,
  output logic [KEY_W-1:0]           key,
  output logic                       mode,
  output logic [SEL_W-1:0]           song_sel,
  output logic                       muting
);

  state_t state;
  state_t target;
  logic   strobe_cycle;
  logic   start;
  logic   done;

  logic [NUM_SONGS-1:0] sel_onehot;
  logic                 sel_key_on;
  logic [KEY_W-1:0]     sel_key;
  logic [SEL_W-1:0]     sel_next;

  assign sel_onehot = NUM_SONGS'(1) << song_sel;
  assign sel_key_on = song_key_on[song_sel];
  assign sel_key    = song_key[int'(song_sel)*KEY_W +: KEY_W];
  assign sel_next   = (song_sel == SEL_W'(NUM_SONGS - 1)) ? '0 : song_sel + 1'b1;

  assign start = ((state == ST_FREE) && mode_btn) ||
                 ((state == ST_AUTO) && (mode_btn || next_btn));

  // The timer covers all but the last gap cycle; that last cycle is the
  // restart-strobe cycle, tracked by strobe_cycle, so the strobe can be
  // registered and still line up with the final gap cycle.
  gap_timer #(
    .LEN(GAP_CYCLES - 1)
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .done (done)
  );

  // Mode FSM with source routing and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_FREE;
      target       <= ST_FREE;
      strobe_cycle <= 1'b0;
      song_sel     <= '0;
      mode         <= 1'b0;
      key_on       <= 1'b0;
      key          <= '0;
      muting       <= 1'b0;
      song_en      <= '0;
      song_rst_n   <= '0;
    end else begin
      song_rst_n <= '1;
      case (state)
        ST_FREE: begin
          if (mode_btn) begin
            state   <= ST_MUTE;
            target  <= ST_AUTO;
            key_on  <= 1'b0;
            muting  <= 1'b1;
            song_en <= '0;
          end else begin
            key_on  <= kb_key_on;
            key     <= kb_key;
            muting  <= 1'b0;
            song_en <= '0;
          end
        end

        ST_AUTO: begin
          if (mode_btn || next_btn) begin
            state   <= ST_MUTE;
            target  <= mode_btn ? ST_FREE : ST_AUTO;
            key_on  <= 1'b0;
            muting  <= 1'b1;
            song_en <= '0;
            if (!mode_btn) begin
              song_sel <= sel_next;
            end
          end else begin
            song_en <= sel_onehot;
            muting  <= 1'b0;
            if (kb_key_on) begin
              key_on <= 1'b1;
              key    <= kb_key;
            end else begin
              key_on <= sel_key_on;
              key    <= sel_key;
            end
          end
        end

        ST_MUTE: begin
          if (strobe_cycle) begin
            state        <= target;
            strobe_cycle <= 1'b0;
            muting       <= 1'b0;
            mode         <= (target == ST_AUTO);
            if (target == ST_AUTO) begin
              song_en <= sel_onehot;
              if (kb_key_on) begin
                key_on <= 1'b1;
                key    <= kb_key;
              end else begin
                key_on <= sel_key_on;
                key    <= sel_key;
              end
            end else begin
              song_en <= '0;
              key_on  <= kb_key_on;
              key     <= kb_key;
            end
          end else begin
            key_on  <= 1'b0;
            muting  <= 1'b1;
            song_en <= '0;
            if (done) begin
              strobe_cycle <= 1'b1;
              if (target == ST_AUTO) begin
                song_rst_n <= ~sel_onehot;
              end
            end
          end
        end

        default: begin
          state <= ST_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_play_source_arbiter.sv
// Self-checking bench for play_source_arbiter with a 4-cycle gap and three
// songs. A behavioural model tracks the expected outputs every cycle; the
// directed sequence walks through the key scenarios, then random traffic
// (buttons, keys, song notes, occasional resets) exercises the rest.
module tb_play_source_arbiter;

  localparam int N   = 3;
  localparam int KW  = 4;
  localparam int SW  = 2;
  localparam int GAP = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            kb_key_on = 1'b0;
  logic [KW-1:0]   kb_key = '0;
  logic [N-1:0]    song_key_on = '0;
  logic [N*KW-1:0] song_key = '0;
  logic            mode_btn = 1'b0;
  logic            next_btn = 1'b0;
  logic [N-1:0]    song_en;
  logic [N-1:0]    song_rst_n;
  logic            key_on;
  logic [KW-1:0]   key;
  logic            mode;
  logic [SW-1:0]   song_sel;
  logic            muting;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = free play, 1 = silent gap, 2 = autoplay.
  int            m_phase = 0;
  int            m_left = 0;
  int            m_sel = 0;
  bit            m_dest_auto = 0;
  logic          m_key_on = 1'b0;
  logic [KW-1:0] m_key = '0;
  logic          m_mode = 1'b0;
  logic [N-1:0]  m_rst_n = '0;

  play_source_arbiter #(
    .NUM_SONGS (N),
    .KEY_W     (KW),
    .SEL_W     (SW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kb_key_on  (kb_key_on),
    .kb_key     (kb_key),
    .song_key_on(song_key_on),
    .song_key   (song_key),
    .mode_btn   (mode_btn),
    .next_btn   (next_btn),
    .song_en    (song_en),
    .song_rst_n (song_rst_n),
    .key_on     (key_on),
    .key        (key),
    .mode       (mode),
    .song_sel   (song_sel),
    .muting     (muting)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load the model outputs for a cycle spent in free play or autoplay.
  task automatic route(input bit auto_mode);
    if (!auto_mode) begin
      m_key_on = kb_key_on;
      m_key    = kb_key;
    end else if (kb_key_on) begin
      m_key_on = 1'b1;
      m_key    = kb_key;
    end else begin
      m_key_on = song_key_on[m_sel];
      m_key    = song_key[m_sel*KW +: KW];
    end
  endtask

  task automatic enter_gap(input bit dest_auto);
    m_phase     = 1;
    m_left      = GAP;
    m_dest_auto = dest_auto;
    m_key_on    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_step();
    if (!rst) begin
      m_phase     = 0;
      m_left      = 0;
      m_sel       = 0;
      m_dest_auto = 0;
      m_key_on    = 1'b0;
      m_key       = '0;
      m_mode      = 1'b0;
      m_rst_n     = '0;
    end else begin
      m_rst_n = '1;
      case (m_phase)
        0: if (mode_btn) enter_gap(1); else route(0);
        2: begin
          if (mode_btn) enter_gap(0);
          else if (next_btn) begin
            m_sel = (m_sel + 1) % N;
            enter_gap(1);
          end else route(1);
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = m_dest_auto ? 2 : 0;
            m_mode  = m_dest_auto;
            route(m_dest_auto);
          end else begin
            m_key_on = 1'b0;
            if (m_left == 1 && m_dest_auto) m_rst_n[m_sel] = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic check_output();
    logic [N-1:0] exp_en;
    exp_en = (m_phase == 2) ? N'(1) << m_sel : '0;
    check_val("key_on",     key_on,     m_key_on);
    check_val("key",        key,        m_key);
    check_val("mode",       mode,       m_mode);
    check_val("song_sel",   song_sel,   m_sel);
    check_val("muting",     muting,     m_phase == 1);
    check_val("song_en",    song_en,    exp_en);
    check_val("song_rst_n", song_rst_n, m_rst_n);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic apply_stimulus(input logic r, input logic kon, input logic [KW-1:0] k,
                                input logic mb, input logic nb);
    rst       = r;
    kb_key_on = kon;
    kb_key    = k;
    mode_btn  = mb;
    next_btn  = nb;
    @(posedge clk);
    model_step();
    #1;
    check_output();
  endtask

  initial begin
    // Song 0 plays note 2; the others play distinct notes that must never leak.
    song_key_on = 3'b111;
    song_key    = {4'd12, 4'd7, 4'd2};

    // Hold reset for three cycles.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      check_val("rst_song_rst_n", song_rst_n, 3'b000);
      check_val("rst_key_on", key_on, 1'b0);
    end

    // Release into free play with a live key.
    apply_stimulus(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    check_val("free_key_on", key_on, 1'b1);
    check_val("free_key", key, 4'd5);
    check_val("free_song_en", song_en, 3'b000);
    check_val("release_song_rst_n", song_rst_n, 3'b111);

    // next_btn ignored in free play.
    apply_stimulus(1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
    check_val("free_next_ignored", muting, 1'b0);

    // Enter autoplay: four silent cycles, restart strobe on the fourth.
    for (int i = 0; i < GAP; i++) begin
      apply_stimulus(1'b1, 1'b0, 4'd0, i == 0, 1'b0);
      check_val("enter_muting", muting, 1'b1);
      check_val("enter_key_on", key_on, 1'b0);
      if (i == GAP - 1) check_val("enter_strobe", song_rst_n, 3'b110);
      else check_val("enter_no_strobe", song_rst_n, 3'b111);
    end
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("auto_mode", mode, 1'b1);
    check_val("auto_song_en", song_en, 3'b001);
    check_val("auto_key", key, 4'd2);
    check_val("auto_muting", muting, 1'b0);

    // Live key pre-empts the song, then the song comes back.
    apply_stimulus(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    check_val("preempt_key", key, 4'd9);
    check_val("preempt_song_en", song_en, 3'b001);
    apply_stimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
    check_val("resume_key", key, 4'd2);
    check_val("resume_song_en", song_en, 3'b001);

    // Step to song 2 with two next presses.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < GAP + 1; i++) apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, i == 0);
    end
    check_val("sel_two", song_sel, 2'd2);
    check_val("sel_two_key", key, 4'd12);

    // Wrap from song 2 back to song 0.
    for (int i = 0; i < GAP; i++) begin
      apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, i == 0);
      if (i == GAP - 1) check_val("wrap_strobe", song_rst_n, 3'b110);
    end
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("wrap_sel", song_sel, 2'd0);
    check_val("wrap_song_en", song_en, 3'b001);

    // Move to song 1, then press both buttons together.
    for (int i = 0; i < GAP + 1; i++) apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, i == 0);
    check_val("sel_one", song_sel, 2'd1);
    for (int i = 0; i < GAP; i++) begin
      apply_stimulus(1'b1, 1'b0, 4'd0, i == 0, (i == 0) || (i == 1));
      check_val("both_sel_kept", song_sel, 2'd1);
      if (i == GAP - 1) check_val("to_free_no_strobe", song_rst_n, 3'b111);
    end
    apply_stimulus(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
    check_val("back_free_mode", mode, 1'b0);
    check_val("back_free_song_en", song_en, 3'b000);
    check_val("back_free_key", key, 4'd6);

    // Autoplay on song 1, then next_btn and reset on gap cycle 2.
    for (int i = 0; i < GAP + 1; i++) apply_stimulus(1'b1, 1'b0, 4'd0, i == 0, 1'b0);
    check_val("auto_sel_one_en", song_en, 3'b010);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("midgap_muting", muting, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("midgap_rst_muting", muting, 1'b0);
    check_val("midgap_rst_sel", song_sel, 2'd0);
    check_val("midgap_rst_song_en", song_en, 3'b000);
    check_val("midgap_rst_song_rst_n", song_rst_n, 3'b000);
    check_val("midgap_rst_mode", mode, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      song_key_on = N'($urandom);
      song_key    = (N*KW)'($urandom);
      apply_stimulus(($urandom_range(0, 199) != 0),
                     ($urandom_range(0, 3) == 0),
                     KW'($urandom),
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
